// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin front end for one shared pipelined FP32 multiplier.
// Each cycle it grants at most one requester and feeds its operands to the
// multiplier. A tag pipeline moves in lock-step with the multiplier so that
// each result goes back to the requester that issued it.
module fmul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_z,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  output logic               mul_enable,
  input  logic [31:0]        mul_z,
  output logic [IDW+1:0]     inflight,
  output logic [31:0]        ops_count
);

  // Tag pipeline: one {valid, id} per multiplier stage; stage LAT-1 is the output stage.
  logic [LAT-1:0]   r_tag_vld;
  logic [IDW-1:0]   r_tag_id [LAT];
  logic [IDW-1:0]   r_ptr;
  logic [31:0]      r_ops_count;
  logic [IDW+1:0]   r_inflight;

  logic             w_out_vld;
  logic [IDW-1:0]   w_out_id;
  logic [NREQ-1:0]  w_out_sel;
  logic             w_out_ready;
  logic             w_advance;
  logic             w_run;
  logic             w_found;
  logic [IDW-1:0]   w_grant;
  logic             w_issue;
  logic             w_complete;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]  w_rot;
  logic [IDW:0]     w_sum;

  assign w_out_vld = r_tag_vld[LAT-1];
  assign w_out_id  = r_tag_id[LAT-1];

  // Decode the output-stage tag into a one-hot requester select.
  always_comb begin
    w_out_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_out_vld && (w_out_id == IDW'(i))) begin
        w_out_sel[i] = 1'b1;
      end else begin
        w_out_sel[i] = 1'b0;
      end
    end
  end

  // The whole pipeline (multiplier and tags) moves only when the output stage
  // is empty or its owner takes the result; a stalled owner stalls everyone.
  assign w_out_ready = |(w_out_sel & rsp_ready);
  assign w_advance   = !w_out_vld || w_out_ready;
  assign w_run       = w_advance && !clr;

  // Round-robin search: rotate the valid vector so bit 0 is the pointer,
  // take the first set bit, then map it back to an absolute index.
  always_comb begin
    w_dbl   = {req_valid, req_valid};
    w_rot   = NREQ'(w_dbl >> r_ptr);
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IDW+1)'(i);
        if (w_sum >= (IDW+1)'(NREQ)) begin
          w_sum = w_sum - (IDW+1)'(NREQ);
        end else begin
          w_sum = w_sum;
        end
        w_grant = w_sum[IDW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_issue    = w_run && w_found;
  assign w_complete = w_run && w_out_vld;

  // Steer the granted requester's operands to the multiplier and strobe its ready.
  always_comb begin
    req_ready = '0;
    mul_a     = 32'h0000_0000;
    mul_b     = 32'h0000_0000;
    for (int i = 0; i < NREQ; i++) begin
      if (w_found && (w_grant == IDW'(i))) begin
        mul_a        = req_a[32*i +: 32];
        mul_b        = req_b[32*i +: 32];
        req_ready[i] = w_run;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Present the output-stage result to its owner; everything is masked during clear.
  always_comb begin
    if (clr) begin
      rsp_valid = '0;
      rsp_z     = 32'h0000_0000;
    end else if (w_out_vld) begin
      rsp_valid = w_out_sel;
      rsp_z     = mul_z;
    end else begin
      rsp_valid = '0;
      rsp_z     = 32'h0000_0000;
    end
  end

  assign mul_enable = w_run;
  assign inflight   = r_inflight;
  assign ops_count  = r_ops_count;

  // Shift the tag pipeline whenever the multiplier is enabled; bubbles stay in place.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_tag_vld <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else if (w_advance) begin
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_grant;
      for (int s = 1; s < LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end else begin
      r_tag_vld <= r_tag_vld;
    end
  end

  // Move the round-robin pointer to the requester after the one just accepted.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      if (w_grant == IDW'(NREQ-1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_grant + IDW'(1);
      end
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Track valid tags in flight and count completed results (wrapping counter).
  always_ff @(posedge clk) begin
    if (clr) begin
      r_inflight  <= '0;
      r_ops_count <= 32'h0000_0000;
    end else begin
      r_inflight  <= r_inflight + (IDW+2)'(w_issue) - (IDW+2)'(w_complete);
      r_ops_count <= r_ops_count + 32'(w_complete);
    end
  end

endmodule
